// File: rtl/switch_conditioner.sv
// Synchronised, debounced switch front-end with latched rise/fall events and per-channel ack.
// Optional registered interrupt output when SWITCH_CONDITIONER_IRQ_EN is defined.
module switch_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clock,
  input  logic                isResetN,
  input  logic [CHANNELS-1:0] switch,
  input  logic [CHANNELS-1:0] eventAck,
  output logic [CHANNELS-1:0] switchLevel,
  output logic [CHANNELS-1:0] risePending,
  output logic [CHANNELS-1:0] fallPending,
`ifdef SWITCH_CONDITIONER_IRQ_EN
  output logic [CHANNELS-1:0] overrun,
  input  logic [CHANNELS-1:0] irqMask,
  output logic                irq
`else
  output logic [CHANNELS-1:0] overrun
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CW-1:0]          cnt_q  [CHANNELS];
  logic [CW-1:0]          cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]    syncd;
  logic [CHANNELS-1:0]    level_q, level_d;
  logic [CHANNELS-1:0]    rise_q, rise_d;
  logic [CHANNELS-1:0]    fall_q, fall_d;
  logic [CHANNELS-1:0]    ovr_q, ovr_d;

  always_comb begin
    syncd = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      syncd[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    logic acc;
    level_d = level_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    ovr_d   = ovr_q;
    acc     = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      acc      = 1'b0;
      cnt_d[i] = cnt_q[i];
      if (syncd[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        acc        = 1'b1;
        level_d[i] = syncd[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end

      // An ack clears old events, but an edge accepted in the same cycle survives it.
      if (eventAck[i]) begin
        rise_d[i] = acc & syncd[i];
        fall_d[i] = acc & ~syncd[i];
        ovr_d[i]  = 1'b0;
      end else if (acc) begin
        if (syncd[i]) rise_d[i] = 1'b1;
        else          fall_d[i] = 1'b1;
        if (rise_q[i] | fall_q[i]) ovr_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      ovr_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], switch[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ovr_q   <= ovr_d;
    end
  end

  assign switchLevel = level_q;
  assign risePending = rise_q;
  assign fallPending = fall_q;
  assign overrun     = ovr_q;

`ifdef SWITCH_CONDITIONER_IRQ_EN
  logic irq_q;

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) irq_q <= 1'b0;
    else           irq_q <= |((rise_q | fall_q) & irqMask);
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner: expectations queued per step, popped and asserted on output.
// Also exercises the irq output when SWITCH_CONDITIONER_IRQ_EN is defined.
module tb_switch_conditioner;

  logic       clock;
  logic       isResetN;
  logic [3:0] switch;
  logic [3:0] eventAck;
  logic [3:0] switchLevel;
  logic [3:0] risePending;
  logic [3:0] fallPending;
  logic [3:0] overrun;
`ifdef SWITCH_CONDITIONER_IRQ_EN
  logic [3:0] irqMask;
  logic       irq;
`endif

  int vectors;
  int miscompares;

  typedef struct {
    string      tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  switch_conditioner #(
    .CHANNELS(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clock(clock),
    .isResetN(isResetN),
    .switch(switch),
    .eventAck(eventAck),
    .switchLevel(switchLevel),
    .risePending(risePending),
    .fallPending(fallPending),
`ifdef SWITCH_CONDITIONER_IRQ_EN
    .overrun(overrun),
    .irqMask(irqMask),
    .irq(irq)
`else
    .overrun(overrun)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input string tag, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] o);
    exp_t e;
    e.tag = tag;
    e.exp = {l, r, f, o};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [15:0] obs;
    obs = {switchLevel, risePending, fallPending, overrun};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty observed=%h expected=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h (level,rise,fall,ovr)", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] o);
    push(tag, l, r, f, o);
    check_out();
  endtask

`ifdef SWITCH_CONDITIONER_IRQ_EN
  task automatic chk_irq(input string tag, input logic exp);
    vectors++;
    assert (irq === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, irq, exp);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    isResetN    = 1'b0;
    switch      = 4'hF;
    eventAck    = 4'h0;
`ifdef SWITCH_CONDITIONER_IRQ_EN
    irqMask     = 4'b0010;
`endif

    // Reset held with switches high, then release.
    tick(3);
    step("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    isResetN = 1'b1;
    tick(17);
    step("rst_e17", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    step("rst_e18", 4'hF, 4'hF, 4'h0, 4'h0);

    eventAck = 4'hF;
    tick(1);
    eventAck = 4'h0;
    step("ack_all", 4'hF, 4'h0, 4'h0, 4'h0);

    switch = 4'h0;
    tick(17);
    step("fall_e17", 4'hF, 4'h0, 4'h0, 4'h0);
    tick(1);
    step("fall_e18", 4'h0, 4'h0, 4'hF, 4'h0);
    eventAck = 4'hF;
    tick(1);
    eventAck = 4'h0;
    step("ack_fall", 4'h0, 4'h0, 4'h0, 4'h0);

    // Glitch: 15 cycles rejected, 16 accepted.
    switch[0] = 1'b1;
    tick(15);
    switch[0] = 1'b0;
    tick(20);
    step("glitch15", 4'h0, 4'h0, 4'h0, 4'h0);
    switch[0] = 1'b1;
    tick(17);
    step("glitch16_e17", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    step("glitch16_e18", 4'h1, 4'h1, 4'h0, 4'h0);
    tick(1);
`ifdef SWITCH_CONDITIONER_IRQ_EN
    chk_irq("irq_masked", 1'b0);
`endif

    // Bounce on ch1, then hold high.
    for (int k = 0; k < 10; k++) begin
      switch[1] = (k % 2 == 0);
      tick(3);
    end
    step("bounce_quiet", 4'h1, 4'h1, 4'h0, 4'h0);
    switch[1] = 1'b1;
    tick(17);
    step("bounce_e17", 4'h1, 4'h1, 4'h0, 4'h0);
    tick(1);
    step("bounce_e18", 4'h3, 4'h3, 4'h0, 4'h0);
`ifdef SWITCH_CONDITIONER_IRQ_EN
    chk_irq("irq_lag", 1'b0);
`endif
    tick(1);
`ifdef SWITCH_CONDITIONER_IRQ_EN
    chk_irq("irq_set", 1'b1);
`endif
    eventAck = 4'h2;
    tick(1);
    eventAck = 4'h0;
    step("ack_ch1", 4'h3, 4'h1, 4'h0, 4'h0);
`ifdef SWITCH_CONDITIONER_IRQ_EN
    chk_irq("irq_hold", 1'b1);
`endif
    tick(1);
`ifdef SWITCH_CONDITIONER_IRQ_EN
    chk_irq("irq_clr", 1'b0);
`endif

    // Overrun on ch2, then ack.
    switch[2] = 1'b1;
    tick(18);
    step("ch2_rise", 4'h7, 4'h5, 4'h0, 4'h0);
    switch[2] = 1'b0;
    tick(18);
    step("ch2_ovr", 4'h3, 4'h5, 4'h4, 4'h4);
    eventAck = 4'h4;
    tick(1);
    eventAck = 4'h0;
    step("ch2_ack", 4'h3, 4'h1, 4'h0, 4'h0);

    // Ack coinciding with an accepted edge: the new event wins.
    switch[2] = 1'b1;
    tick(18);
    step("ch2_rise2", 4'h7, 4'h5, 4'h0, 4'h0);
    switch[2] = 1'b0;
    tick(18);
    step("ch2_ovr2", 4'h3, 4'h5, 4'h4, 4'h4);
    switch[2] = 1'b1;
    tick(17);
    eventAck = 4'h4;
    tick(1);
    eventAck = 4'h0;
    step("ch2_ack_coincide", 4'h7, 4'h5, 4'h0, 4'h0);
    eventAck = 4'h4;
    tick(1);
    eventAck = 4'h0;
    step("ch2_ack_clear", 4'h7, 4'h1, 4'h0, 4'h0);
    eventAck = 4'h4;
    tick(1);
    eventAck = 4'h0;
    step("ack_idle", 4'h7, 4'h1, 4'h0, 4'h0);

    // Reset midway between edges with cnt[3]=10 and ch0 pending.
    switch[3] = 1'b1;
    tick(12);
    #9;
    isResetN = 1'b0;
    #1;
    step("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0);
`ifdef SWITCH_CONDITIONER_IRQ_EN
    chk_irq("irq_rst", 1'b0);
`endif
    tick(1);
    step("rst_mid_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    isResetN = 1'b1;
    tick(17);
    step("rst_mid_e17", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    step("rst_mid_e18", 4'hF, 4'hF, 4'h0, 4'h0);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
